// File: rtl/mult8_seq_if.sv
// Operand/result bundle between the register-file controller and the 8x8 multiplier.
interface mult8_seq_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prod_low;
    logic [7:0] mult_high;
    logic       busy;
    logic       done;
    logic       wr_high_n;

    modport master (
        output start, a, b,
        input  prod_low, mult_high, busy, done, wr_high_n
    );

    modport slave (
        input  start, a, b,
        output prod_low, mult_high, busy, done, wr_high_n
    );
endinterface

// File: rtl/mult8_seq.sv
// Sequential 8x8 shift-add multiplier: one step per cycle, product loaded into
// output flops only on completion so partial results are never visible.
module mult8_seq #(
    parameter bit SIGNED = 1'b0
) (
    input logic        clk,
    input logic        rst,
    mult8_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q;
    logic [7:0] ma_q, mb_q, acc_q;
    logic [3:0] cnt_q;
    logic       neg_q;
    logic [7:0] prod_low_q, mult_high_q;
    logic       busy_q, done_q, wr_high_n_q;

    logic [8:0]  sum;
    logic [7:0]  acc_step, mb_step;
    logic [15:0] prod_mag, prod_fin;
    logic [7:0]  a_mag, b_mag;

    always_comb begin
        sum = {1'b0, acc_q};
        if (mb_q[0]) sum = {1'b0, acc_q} + {1'b0, ma_q};
        acc_step = sum[8:1];
        mb_step  = {sum[0], mb_q[7:1]};
        prod_mag = {acc_step, mb_step};
        prod_fin = neg_q ? (~prod_mag) + 16'd1 : prod_mag;
        // 0x80 negates to itself, which is the correct unsigned magnitude 128
        a_mag = (SIGNED && bus.a[7]) ? (~bus.a) + 8'd1 : bus.a;
        b_mag = (SIGNED && bus.b[7]) ? (~bus.b) + 8'd1 : bus.b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ma_q        <= 8'h00;
            mb_q        <= 8'h00;
            acc_q       <= 8'h00;
            cnt_q       <= 4'd0;
            neg_q       <= 1'b0;
            prod_low_q  <= 8'h00;
            mult_high_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_high_n_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        ma_q    <= a_mag;
                        mb_q    <= b_mag;
                        acc_q   <= 8'h00;
                        cnt_q   <= 4'd0;
                        neg_q   <= SIGNED && (bus.a[7] ^ bus.b[7]);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    mb_q  <= mb_step;
                    cnt_q <= cnt_q + 4'd1;
                    // Eighth step: publish the finished product on the same edge
                    if (cnt_q == 4'd7) begin
                        {mult_high_q, prod_low_q} <= prod_fin;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        wr_high_n_q <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    done_q      <= 1'b0;
                    wr_high_n_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.prod_low  = prod_low_q;
    assign bus.mult_high = mult_high_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_high_n = wr_high_n_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Self-checking bench for mult8_seq: unsigned and signed instances against an
// arithmetic reference model, with directed corner cases and random operands.
module tb_mult8_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] last_prod [2];

    always #5 clk = ~clk;

    mult8_seq_if u_bus ();
    mult8_seq_if s_bus ();

    mult8_seq #(.SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .bus(u_bus));
    mult8_seq #(.SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(s_bus));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input bit sel, input logic [7:0] av,
                                             input logic [7:0] bv);
        int p;
        if (sel) p = int'($signed(av)) * int'($signed(bv));
        else     p = int'(av) * int'(bv);
        return p[15:0];
    endfunction

    function automatic logic [15:0] obs_prod(input bit sel);
        return sel ? {s_bus.mult_high, s_bus.prod_low} : {u_bus.mult_high, u_bus.prod_low};
    endfunction

    function automatic logic obs_busy(input bit sel);
        return sel ? s_bus.busy : u_bus.busy;
    endfunction

    function automatic logic obs_done(input bit sel);
        return sel ? s_bus.done : u_bus.done;
    endfunction

    function automatic logic obs_wr(input bit sel);
        return sel ? s_bus.wr_high_n : u_bus.wr_high_n;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [7:0] av,
                         input logic [7:0] bv);
        if (sel) begin
            s_bus.start = st; s_bus.a = av; s_bus.b = bv;
        end else begin
            u_bus.start = st; u_bus.a = av; u_bus.b = bv;
        end
    endtask

    // Called #1 after an edge; start is accepted on the next edge (N).
    task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
        drive(sel, 1'b1, av, bv);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        check_val("busy_accept", obs_busy(sel), 1);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check_val("busy_run", {obs_busy(sel), obs_done(sel)}, 2'b10);
            if (k == 4) check_val("hold_prev", obs_prod(sel), last_prod[sel]);
        end
        @(posedge clk); #1;
        check_val("done_flags", {obs_busy(sel), obs_done(sel), obs_wr(sel)}, 3'b010);
        check_val("product", obs_prod(sel), exp);
        @(posedge clk); #1;
        check_val("after_done", {obs_busy(sel), obs_done(sel), obs_wr(sel)}, 3'b001);
        check_val("product_hold", obs_prod(sel), exp);
        last_prod[sel] = exp;
    endtask

    initial begin
        int dones;
        logic [7:0] av, bv;
        last_prod[0] = 16'h0000;
        last_prod[1] = 16'h0000;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00);

        // Reset, then idle for 20 cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_u", {obs_prod(0), obs_busy(0), obs_done(0), obs_wr(0)}, 19'h00001);
        check_val("rst_s", {obs_prod(1), obs_busy(1), obs_done(1), obs_wr(1)}, 19'h00001);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check_val("idle_u", {obs_prod(0), obs_busy(0), obs_done(0), obs_wr(0)}, 19'h00001);
            check_val("idle_s", {obs_prod(1), obs_busy(1), obs_done(1), obs_wr(1)}, 19'h00001);
        end

        // Directed unsigned and signed cases
        run_op(1'b0, 8'h0C, 8'h0A, 16'h0078);
        run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op(1'b0, 8'h00, 8'hB7, 16'h0000);
        run_op(1'b0, 8'h80, 8'h02, 16'h0100);
        run_op(1'b1, 8'hFF, 8'hFF, 16'h0001);
        run_op(1'b1, 8'h80, 8'h80, 16'h4000);
        run_op(1'b1, 8'h80, 8'h01, 16'hFF80);
        run_op(1'b1, 8'h05, 8'hFD, 16'hFFF1);

        // Random operands against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            run_op(1'b0, av, bv, ref_prod(1'b0, av, bv));
            av = 8'($urandom); bv = 8'($urandom);
            run_op(1'b1, av, bv, ref_prod(1'b1, av, bv));
        end

        // Start while busy and in DONE is ignored
        dones = 0;
        drive(1'b0, 1'b1, 8'h03, 8'h04);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (obs_done(0)) dones++;
            if (k == 2 || k == 8) drive(1'b0, 1'b1, 8'h11, 8'h11);
            if (k == 3 || k == 9) drive(1'b0, 1'b0, 8'h00, 8'h00);
            if (k == 8)  check_val("busy_ign_prod", obs_prod(0), 16'h000C);
            if (k == 10) check_val("busy_ign_idle", obs_busy(0), 0);
            if (k == 20) check_val("busy_ign_late", {obs_busy(0), obs_prod(0)}, 17'h0000C);
        end
        check_val("busy_ign_dones", dones, 1);
        last_prod[0] = 16'h000C;

        // Reset in the middle of an operation
        run_op(1'b0, 8'h0C, 8'h0A, 16'h0078);
        drive(1'b0, 1'b1, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("midrst_u", {obs_prod(0), obs_busy(0), obs_done(0), obs_wr(0)}, 19'h00001);
        check_val("midrst_s", obs_prod(1), 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        last_prod[0] = 16'h0000;
        last_prod[1] = 16'h0000;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (obs_done(0)) dones++;
        end
        check_val("midrst_nodone", {dones[3:0], obs_prod(0)}, 20'h00000);
        run_op(1'b0, 8'h0C, 8'h0A, 16'h0078);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
